// File: rtl/peridot_board_inforom.sv
// PERIDOT board info ROM: acquires the chip UID, then serves "header + UID as ASCII hex" over a req/ack read port.
// Define PERIDOT_INFOROM_CRC_EN to append a CRC-8 (poly 0x07) byte to the image.
module peridot_board_inforom #(
    parameter int                         UID_NIBBLES = 16,
    parameter int                         HEADER_LEN  = 10,
    parameter logic [8*HEADER_LEN-1:0]    HEADER_STR  = 80'h4A375703_4A37324E3933,
    parameter logic [4*UID_NIBBLES-1:0]   UID_VALUE   = '1,
    parameter int                         UID_TIMEOUT = 255,
    parameter int                         ADDR_W      = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*UID_NIBBLES-1:0]  uid_in,
    input  logic                      uid_in_valid,
    output logic                      uid_prim_reset,
    output logic                      ready,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_ack,
    output logic [7:0]                rd_data,
    output logic [4*UID_NIBBLES-1:0]  uid,
    output logic                      uid_valid,
    output logic                      uid_timeout,
    output logic [ADDR_W-1:0]         image_len
);
    localparam int W      = 4*UID_NIBBLES;
`ifdef PERIDOT_INFOROM_CRC_EN
    localparam int IMG_LEN = HEADER_LEN + UID_NIBBLES + 1;
`else
    localparam int IMG_LEN = HEADER_LEN + UID_NIBBLES;
`endif
    localparam bit ACQ_EN  = (UID_TIMEOUT != 0);
    localparam int TO_W    = (UID_TIMEOUT > 1) ? $clog2(UID_TIMEOUT) : 1;
    localparam int TO_LAST = (UID_TIMEOUT > 0) ? UID_TIMEOUT - 1 : 0;

`ifdef PERIDOT_INFOROM_CRC_EN
    typedef enum logic [2:0] {S_WAIT, S_CAPTURE, S_FIXED, S_CRC, S_READY} state_t;
`else
    typedef enum logic [2:0] {S_WAIT, S_CAPTURE, S_FIXED, S_READY} state_t;
`endif

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [W-1:0]      uid_q, uid_d;
    logic              uid_valid_q, uid_valid_d;
    logic              uid_timeout_q, uid_timeout_d;
    logic              ready_q, ready_d;
    logic              rd_ack_q, rd_ack_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        rd_byte;
    logic              finish;
`ifdef PERIDOT_INFOROM_CRC_EN
    logic [7:0]        crc_q, crc_d;
    logic [ADDR_W-1:0] crc_addr_q, crc_addr_d;
`endif

    // Header / UID-hex portion of the image; out-of-range addresses read 0xFF.
    function automatic logic [7:0] byte_at(input logic [ADDR_W-1:0] a, input logic [W-1:0] u);
        int         ai;
        int         ni;
        logic [3:0] nib;
        ai      = int'(a);
        byte_at = 8'hFF;
        if (ai < HEADER_LEN) begin
            byte_at = HEADER_STR[8*(HEADER_LEN-1-ai) +: 8];
        end else if (ai < HEADER_LEN + UID_NIBBLES) begin
            ni      = ai - HEADER_LEN;
            nib     = u[4*(UID_NIBBLES-1-ni) +: 4];
            byte_at = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        end
    endfunction

`ifdef PERIDOT_INFOROM_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction
`endif

    always_comb begin
        rd_byte = byte_at(rd_addr, uid_q);
`ifdef PERIDOT_INFOROM_CRC_EN
        if (rd_addr == ADDR_W'(IMG_LEN - 1)) begin
            rd_byte = crc_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        tcnt_d        = tcnt_q;
        uid_d         = uid_q;
        uid_valid_d   = uid_valid_q;
        uid_timeout_d = uid_timeout_q;
        ready_d       = ready_q;
        rd_ack_d      = rd_req;
        rd_data_d     = rd_data_q;
        finish        = 1'b0;
`ifdef PERIDOT_INFOROM_CRC_EN
        crc_d         = crc_q;
        crc_addr_d    = crc_addr_q;
`endif
        if (rd_req) begin
            rd_data_d = ready_q ? rd_byte : 8'hFF;
        end

        case (state_q)
            S_WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == 4'd15) begin
                    state_d = ACQ_EN ? S_CAPTURE : S_FIXED;
                end
            end
            S_CAPTURE: begin
                // A valid UID arriving on the expiry edge takes priority over the fallback.
                if (uid_in_valid) begin
                    uid_d       = uid_in;
                    uid_valid_d = 1'b1;
                    finish      = 1'b1;
                end else if (tcnt_q == TO_W'(TO_LAST)) begin
                    uid_d         = UID_VALUE;
                    uid_timeout_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_FIXED: begin
                uid_d         = UID_VALUE;
                uid_valid_d   = 1'b1;
                uid_timeout_d = 1'b0;
                finish        = 1'b1;
            end
`ifdef PERIDOT_INFOROM_CRC_EN
            S_CRC: begin
                crc_d = crc8_step(crc_q, byte_at(crc_addr_q, uid_q));
                if (crc_addr_q == ADDR_W'(IMG_LEN - 2)) begin
                    ready_d = 1'b1;
                    state_d = S_READY;
                end else begin
                    crc_addr_d = crc_addr_q + 1'b1;
                end
            end
`endif
            S_READY: ready_d = 1'b1;
            default: state_d = S_WAIT;
        endcase

        if (finish) begin
`ifdef PERIDOT_INFOROM_CRC_EN
            // Byte 0 is header-only, so it is folded in on the UID latch edge.
            state_d    = S_CRC;
            crc_d      = crc8_step(8'h00, HEADER_STR[8*HEADER_LEN-1 -: 8]);
            crc_addr_d = ADDR_W'(1);
`else
            state_d = S_READY;
            ready_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q        <= 4'd0;
            tcnt_q        <= '0;
            uid_q         <= UID_VALUE;
            uid_valid_q   <= 1'b0;
            uid_timeout_q <= 1'b0;
            ready_q       <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= 8'hFF;
`ifdef PERIDOT_INFOROM_CRC_EN
            crc_q         <= 8'h00;
            crc_addr_q    <= '0;
`endif
        end else begin
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
            uid_q         <= uid_d;
            uid_valid_q   <= uid_valid_d;
            uid_timeout_q <= uid_timeout_d;
            ready_q       <= ready_d;
            rd_ack_q      <= rd_ack_d;
            rd_data_q     <= rd_data_d;
`ifdef PERIDOT_INFOROM_CRC_EN
            crc_q         <= crc_d;
            crc_addr_q    <= crc_addr_d;
`endif
        end
    end

    assign uid_prim_reset = (state_q == S_WAIT) && (wcnt_q < 4'd8);
    assign ready          = ready_q;
    assign rd_ack         = rd_ack_q;
    assign rd_data        = rd_data_q;
    assign uid            = uid_q;
    assign uid_valid      = uid_valid_q;
    assign uid_timeout    = uid_timeout_q;
    assign image_len      = ADDR_W'(IMG_LEN);

endmodule

// File: tb/tb_peridot_board_inforom.sv
// Directed self-checking bench for peridot_board_inforom (default parameters plus a UID_TIMEOUT=0 instance).
`timescale 1ns/1ps
module tb_peridot_board_inforom;
`ifdef PERIDOT_INFOROM_CRC_EN
    localparam int X = 25;
    localparam int N = 27;
`else
    localparam int X = 0;
    localparam int N = 26;
`endif
    localparam logic [7:0] HDR [10] = '{8'h4A, 8'h37, 8'h57, 8'h03, 8'h4A,
                                        8'h37, 8'h32, 8'h4E, 8'h39, 8'h33};
    localparam logic [63:0] UID_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, reset_n_b;
    logic [63:0] uid_in;
    logic        uid_in_valid;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        uid_prim_reset, ready, rd_ack, uid_valid, uid_timeout;
    logic [7:0]  rd_data;
    logic [63:0] uid;
    logic [5:0]  image_len;
    logic        uid_prim_reset_b, ready_b, rd_ack_b, uid_valid_b, uid_timeout_b;
    logic [7:0]  rd_data_b;
    logic [63:0] uid_b;
    logic [5:0]  image_len_b;
    logic        rd_req_b;
    logic [5:0]  rd_addr_b;

    int checks = 0;
    int errors = 0;

    peridot_board_inforom dut (
        .clk(clk), .reset_n(reset_n), .uid_in(uid_in), .uid_in_valid(uid_in_valid),
        .uid_prim_reset(uid_prim_reset), .ready(ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .uid(uid), .uid_valid(uid_valid),
        .uid_timeout(uid_timeout), .image_len(image_len)
    );

    peridot_board_inforom #(.UID_TIMEOUT(0)) dut_fixed (
        .clk(clk), .reset_n(reset_n_b), .uid_in(uid_in), .uid_in_valid(uid_in_valid),
        .uid_prim_reset(uid_prim_reset_b), .ready(ready_b), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
        .rd_ack(rd_ack_b), .rd_data(rd_data_b), .uid(uid_b), .uid_valid(uid_valid_b),
        .uid_timeout(uid_timeout_b), .image_len(image_len_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read1(input logic [5:0] a, input string tag, input logic [7:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        tick(1);
        check_eq({tag, "_ack"}, 64'(rd_ack), 64'd1);
        check_eq(tag, 64'(rd_data), 64'(exp));
        rd_req = 1'b0;
    endtask

    function automatic logic [7:0] model_byte(input int i, input logic [63:0] u);
        logic [3:0] nib;
        if (i < 10) return HDR[i];
        if (i < 26) begin
            nib = u[4*(25-i) +: 4];
            return (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10;
        end
        return 8'hFF;
    endfunction

    function automatic logic [7:0] crc_model(input logic [63:0] u);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 26; i++) begin
            c = c ^ model_byte(i, u);
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 64'(ready), 64'd0);
        check_eq({tag, "_ack"}, 64'(rd_ack), 64'd0);
        check_eq({tag, "_data"}, 64'(rd_data), 64'hFF);
        check_eq({tag, "_uid"}, uid, ONES);
        check_eq({tag, "_uid_valid"}, 64'(uid_valid), 64'd0);
        check_eq({tag, "_prim_rst"}, 64'(uid_prim_reset), 64'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        reset_n_b    = 1'b0;
        uid_in       = UID_A;
        uid_in_valid = 1'b1;
        rd_req       = 1'b0;
        rd_addr      = '0;
        rd_req_b     = 1'b0;
        rd_addr_b    = '0;

        // Power-up with a valid UID already present
        tick(2);
        reset_n = 1'b1;
        check_reset_state("por");
        check_eq("image_len", 64'(image_len), 64'(N));
        read1(6'd0, "early_read", 8'hFF);
        tick(1);
        check_eq("idle_ack", 64'(rd_ack), 64'd0);
        tick(14 + X);
        check_eq("ready_before", 64'(ready), 64'd0);
        tick(1);
        check_eq("ready_edge", 64'(ready), 64'd1);
        check_eq("uid_valid", 64'(uid_valid), 64'd1);
        check_eq("uid_timeout", 64'(uid_timeout), 64'd0);
        check_eq("uid_latched", uid, UID_A);
        check_eq("prim_rst_low", 64'(uid_prim_reset), 64'd0);

        // Back-to-back reads
        rd_req  = 1'b1;
        rd_addr = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq($sformatf("b2b%0d_ack", i), 64'(rd_ack), 64'd1);
            check_eq($sformatf("b2b%0d_data", i), 64'(rd_data), 64'(HDR[i]));
            rd_addr = 6'(i + 1);
        end
        rd_req = 1'b0;
        tick(1);
        check_eq("hold_ack", 64'(rd_ack), 64'd0);
        check_eq("hold_data", 64'(rd_data), 64'h57);

        read1(6'd3, "addr3", 8'h03);
        read1(6'd7, "addr7", 8'h4E);
        read1(6'd10, "addr10", 8'h30);
        read1(6'd25, "addr25", 8'h46);
`ifdef PERIDOT_INFOROM_CRC_EN
        read1(6'd26, "crc", crc_model(UID_A));
        read1(6'd27, "addr27", 8'hFF);
`else
        read1(6'd26, "addr26", 8'hFF);
`endif

        // Reset with a read in flight
        read1(6'd1, "pre_rst_read", 8'h37);
        rd_req  = 1'b1;
        rd_addr = 6'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("rst_inflight");
        tick(1);
        check_eq("rst_cut_ack", 64'(rd_ack), 64'd0);
        rd_req  = 1'b0;
        reset_n = 1'b1;
        tick(16 + X);
        check_eq("rerun_ready_before", 64'(ready), 64'd0);
        tick(1);
        check_eq("rerun_ready_edge", 64'(ready), 64'd1);

        // Reset mid-sequence (inside the CRC walk when compiled in)
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(20);
        reset_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        tick(1);
        reset_n = 1'b1;
        tick(16 + X);
        check_eq("rerun2_ready_before", 64'(ready), 64'd0);
        tick(1);
        check_eq("rerun2_ready_edge", 64'(ready), 64'd1);

        // Acquisition timeout
        uid_in_valid = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(270);
        check_eq("to_before", 64'(uid_timeout), 64'd0);
        tick(1);
        check_eq("to_edge", 64'(uid_timeout), 64'd1);
        check_eq("to_uid_valid", 64'(uid_valid), 64'd0);
        check_eq("to_uid", uid, ONES);
        tick(X);
        check_eq("to_ready", 64'(ready), 64'd1);
        for (int a = 10; a <= 25; a++) begin
            read1(6'(a), $sformatf("to_addr%0d", a), 8'h46);
        end
`ifdef PERIDOT_INFOROM_CRC_EN
        read1(6'd26, "to_crc", crc_model(ONES));
`endif

        // Acquisition disabled
        check_eq("fx_prim_rst0", 64'(uid_prim_reset_b), 64'd1);
        reset_n_b = 1'b1;
        tick(7);
        check_eq("fx_prim_rst7", 64'(uid_prim_reset_b), 64'd1);
        tick(1);
        check_eq("fx_prim_rst8", 64'(uid_prim_reset_b), 64'd0);
        tick(8);
        check_eq("fx_valid_before", 64'(uid_valid_b), 64'd0);
        tick(1);
        check_eq("fx_valid_edge", 64'(uid_valid_b), 64'd1);
        check_eq("fx_timeout", 64'(uid_timeout_b), 64'd0);
        check_eq("fx_uid", uid_b, ONES);
        tick(X);
        check_eq("fx_ready", 64'(ready_b), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
